ysyx_23060236_csr_trap_unit: RTL
================================

// Module: ysyx_23060236_csr_trap_unit
// PURPOSE
//  Machine-mode CSR file with trap sequencing. Successor to the fixed ecall/mret CSR block.
//  Adds:
//  - parametrised reset/ID values
//  - CSRRW/CSRRS/CSRRC ops
//  - mstatus MIE/MPIE stacking, ebreak, illegal-CSR detect
//  - mie/mip with a timer interrupt
//  - optional 64-bit mcycle/minstret
//  Sits beside the EXU; commits only on the retire strobe `valid`.
// PARAMETERS
//  MTVEC_RST     32'h0000_0000  mtvec reset value
//  MSTATUS_RST   32'h0000_1800  mstatus reset value (MPP=11)
//  MVENDORID_VAL 32'h7973_7978  read-only mvendorid
//  MARCHID_VAL   32'h015f_df0c  read-only marchid
// PORTS
//  clock       in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  valid       in   1   instruction retires this cycle; all state updates gated by it
//  csr_addr    in   12  CSR address
//  csr_op      in   2   00 none, 01 write, 10 set, 11 clear
//  wdata       in   32  rs1/zimm operand
//  rdata       out  32  old CSR value (combinational); 0 when illegal
//  illegal     out  1   csr_op!=0 and addr unimplemented, or write to read-only CSR
//  inst_ecall  in   1   ecall retiring
//  inst_ebreak in   1   ebreak retiring
//  inst_mret   in   1   mret retiring
//  epc         in   32  PC of the retiring instruction
//  irq_timer   in   1   level timer interrupt from CLINT
//  irq_take    out  1   interrupt taken; core must squash the retiring instruction
//  jump        out  32  redirect target
//  jump_en     out  1   redirect valid
// BEHAVIOUR
//  - Reset (async) values: mstatus=MSTATUS_RST, mtvec=MTVEC_RST, mepc=0, mcause=0, mie=0, satp=0.
//    Outputs follow combinationally: irq_take=0, jump_en=0.
//  - Implemented CSRs: mstatus 300, mie 304, mtvec 305, mepc 341, mcause 342, mip 344 (RO),
//    satp 180, mvendorid F11 (RO), marchid F12 (RO).
//  - Write value: op01 = wdata; op10 = old|wdata; op11 = old&~wdata.
//    Write takes effect at the clock edge with valid=1 and illegal=0; op10/op11 always write.
//  - mcause is stored as {bit31, bits[5:0]} and read zero-extended in between.
//  - mepc[1:0] and mtvec[1:0] always read 0 (direct mode only).
//  - mip.MTIP (bit 7) = irq_timer, combinational, not writable.
//  - irq_take = valid & mstatus.MIE & mie.MTIE & irq_timer.
//  - Priority within one valid cycle: irq_take > ecall > ebreak > illegal > mret > CSR write.
//    The lower-priority actions are suppressed.
//  - Trap entry (irq, ecall, ebreak, illegal):
//    - mepc <= epc
//    - mcause <= 32'h8000_0007 / 11 / 3 / 2 respectively
//    - MPIE <= MIE, MIE <= 0, MPP <= 11
//    - jump = mtvec, jump_en = 1 in the same cycle
//  - mret: MIE <= MPIE, MPIE <= 1; jump = mepc, jump_en = 1.
//  - jump_en is combinational and qualified by valid; jump = 0 when jump_en = 0.
//  - rdata is the pre-update value, so a read-modify-write in one cycle returns the old value.
//  - valid=0: no state change except the counters; all trap inputs are ignored.
// CONFIGURATION
//  YSYX_23060236_CSR_COUNTERS_EN
//  - Defined:
//    - Adds 64-bit mcycle (B00/B80) and minstret (B02/B82), plus RO aliases cycle (C00/C80)
//      and instret (C02/C82). Reset value 0.
//    - mcycle increments every cycle, independent of valid.
//    - minstret increments on valid & ~trap-entry.
//    - Both wrap 2^64-1 -> 0. A carry from the low to the high half lands in the same edge.
//    - A CSR write to either half overrides that counter's increment in that cycle.
//  - Undefined: these addresses are illegal and no counter flops are built.
// TESTING
//  1. reset mid-run with mtvec=80000100 -> mstatus reads 1800 and mtvec reads MTVEC_RST
//     immediately, without waiting for a clock edge.
//  2. csrrw mtvec,80000100; csrrs mstatus,8; csrrc mstatus,8
//     -> rdata returns 1800, then 1808; mstatus ends at 1800.
//  3. ecall with epc=80000010, mtvec=80000100, MIE=1 -> jump_en=1, jump=80000100;
//     then mepc=80000010, mcause=11, MIE=0, MPIE=1; mret -> jump=80000010, MIE=1.
//  4. MIE=1, mie=80, irq_timer=1, same cycle as ecall and a CSR write
//     -> irq_take=1, mcause=80000007, ecall and write dropped; with MIE=0 -> irq_take=0.
//  5. csr_op=01 on addr 7C0, then write to F11 -> illegal=1, trap with mcause=2,
//     F11 still reads 79737978.
//  6. COUNTERS_EN: write mcycle=FFFFFFFF, mcycleh=0 -> after 2 clocks mcycle=1, mcycleh=1;
//     10 valid retires -> minstret=10.

Source files
------------

// File: rtl/ysyx_23060236_csr_trap_unit_if.sv
// Retire-side bundle between the EXU and the machine-mode CSR/trap unit.
// The core drives through the master modport; the CSR unit is the slave.
interface ysyx_23060236_csr_trap_unit_if;
  logic        valid;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        illegal;
  logic        inst_ecall;
  logic        inst_ebreak;
  logic        inst_mret;
  logic [31:0] epc;
  logic        irq_timer;
  logic        irq_take;
  logic [31:0] jump;
  logic        jump_en;

  modport master (
    output valid, csr_addr, csr_op, wdata, inst_ecall, inst_ebreak, inst_mret, epc, irq_timer,
    input  rdata, illegal, irq_take, jump, jump_en
  );

  modport slave (
    input  valid, csr_addr, csr_op, wdata, inst_ecall, inst_ebreak, inst_mret, epc, irq_timer,
    output rdata, illegal, irq_take, jump, jump_en
  );
endinterface

// File: rtl/ysyx_23060236_csr_trap_unit.sv
// Machine-mode CSR file with trap sequencing (irq/ecall/ebreak/illegal/mret).
// Define YSYX_23060236_CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters.
module ysyx_23060236_csr_trap_unit #(
  parameter logic [31:0] MTVEC_RST     = 32'h0000_0000,
  parameter logic [31:0] MSTATUS_RST   = 32'h0000_1800,
  parameter logic [31:0] MVENDORID_VAL = 32'h7973_7978,
  parameter logic [31:0] MARCHID_VAL   = 32'h015f_df0c
) (
  input logic                          clock,
  input logic                          reset,
  ysyx_23060236_csr_trap_unit_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_SATP      = 12'h180;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
`ifdef YSYX_23060236_CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

  logic [31:0] mstatus_r;
  logic [31:0] mie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mepc_r;
  logic        mcause_int_r;
  logic [5:0]  mcause_code_r;
  logic [31:0] satp_r;

  logic [31:0] old_s;
  logic        hit_s;
  logic        ro_s;
  logic        illegal_s;
  logic [31:0] wval_s;
  logic        irq_s;
  logic        trap_s;
  logic        mret_s;
  logic        wr_s;
  logic [31:0] cause_s;

`ifdef YSYX_23060236_CSR_COUNTERS_EN
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;
  logic [63:0] mcycle_nx_s;
  logic [63:0] minstret_nx_s;
`endif

  // Read decode: old value, address hit and read-only flag
  always_comb begin
    old_s = 32'h0000_0000;
    hit_s = 1'b1;
    ro_s  = 1'b0;
    case (bus.csr_addr)
      ADDR_MSTATUS:   old_s = mstatus_r;
      ADDR_MIE:       old_s = mie_r;
      ADDR_MTVEC:     old_s = mtvec_r;
      ADDR_MEPC:      old_s = mepc_r;
      ADDR_MCAUSE:    old_s = {mcause_int_r, 25'h0, mcause_code_r};
      ADDR_MIP:       begin old_s = {24'h0, bus.irq_timer, 7'h0}; ro_s = 1'b1; end
      ADDR_SATP:      old_s = satp_r;
      ADDR_MVENDORID: begin old_s = MVENDORID_VAL; ro_s = 1'b1; end
      ADDR_MARCHID:   begin old_s = MARCHID_VAL;   ro_s = 1'b1; end
`ifdef YSYX_23060236_CSR_COUNTERS_EN
      ADDR_MCYCLE:    old_s = mcycle_r[31:0];
      ADDR_MCYCLEH:   old_s = mcycle_r[63:32];
      ADDR_MINSTRET:  old_s = minstret_r[31:0];
      ADDR_MINSTRETH: old_s = minstret_r[63:32];
      ADDR_CYCLE:     begin old_s = mcycle_r[31:0];    ro_s = 1'b1; end
      ADDR_CYCLEH:    begin old_s = mcycle_r[63:32];   ro_s = 1'b1; end
      ADDR_INSTRET:   begin old_s = minstret_r[31:0];  ro_s = 1'b1; end
      ADDR_INSTRETH:  begin old_s = minstret_r[63:32]; ro_s = 1'b1; end
`endif
      default:        hit_s = 1'b0;
    endcase
  end

  // Write value and trap/mret/write arbitration for the retiring instruction
  always_comb begin
    case (bus.csr_op)
      2'b01:   wval_s = bus.wdata;
      2'b10:   wval_s = old_s | bus.wdata;
      2'b11:   wval_s = old_s & ~bus.wdata;
      default: wval_s = old_s;
    endcase
    illegal_s = (bus.csr_op != 2'b00) && (!hit_s || ro_s);
    irq_s     = bus.valid && mstatus_r[3] && mie_r[7] && bus.irq_timer;
    trap_s    = bus.valid && (irq_s || bus.inst_ecall || bus.inst_ebreak || illegal_s);
    mret_s    = bus.valid && !trap_s && bus.inst_mret;
    wr_s      = bus.valid && !trap_s && !bus.inst_mret && (bus.csr_op != 2'b00);
    if (irq_s) begin
      cause_s = 32'h8000_0007;
    end else if (bus.inst_ecall) begin
      cause_s = 32'd11;
    end else if (bus.inst_ebreak) begin
      cause_s = 32'd3;
    end else begin
      cause_s = 32'd2;
    end
  end

  // Outputs: old value, redirect target and interrupt acceptance
  always_comb begin
    bus.rdata    = illegal_s ? 32'h0000_0000 : old_s;
    bus.illegal  = illegal_s;
    bus.irq_take = irq_s;
    bus.jump_en  = trap_s || mret_s;
    if (trap_s) begin
      bus.jump = mtvec_r;
    end else if (mret_s) begin
      bus.jump = mepc_r;
    end else begin
      bus.jump = 32'h0000_0000;
    end
  end

  // mstatus: trap pushes MIE into MPIE and forces MPP=11; mret pops it back
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mstatus_r <= MSTATUS_RST;
    end else if (trap_s) begin
      mstatus_r <= {mstatus_r[31:13], 2'b11, mstatus_r[10:8], mstatus_r[3],
                    mstatus_r[6:4], 1'b0, mstatus_r[2:0]};
    end else if (mret_s) begin
      mstatus_r <= {mstatus_r[31:8], 1'b1, mstatus_r[6:4], mstatus_r[7], mstatus_r[2:0]};
    end else if (wr_s && bus.csr_addr == ADDR_MSTATUS) begin
      mstatus_r <= wval_s;
    end
  end

  // Remaining machine CSRs; low two bits of mepc/mtvec are held at zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mie_r         <= 32'h0000_0000;
      mtvec_r       <= {MTVEC_RST[31:2], 2'b00};
      mepc_r        <= 32'h0000_0000;
      mcause_int_r  <= 1'b0;
      mcause_code_r <= 6'h00;
      satp_r        <= 32'h0000_0000;
    end else if (trap_s) begin
      mepc_r        <= {bus.epc[31:2], 2'b00};
      mcause_int_r  <= cause_s[31];
      mcause_code_r <= cause_s[5:0];
    end else if (wr_s) begin
      case (bus.csr_addr)
        ADDR_MIE:    mie_r   <= wval_s;
        ADDR_MTVEC:  mtvec_r <= {wval_s[31:2], 2'b00};
        ADDR_MEPC:   mepc_r  <= {wval_s[31:2], 2'b00};
        ADDR_MCAUSE: begin mcause_int_r <= wval_s[31]; mcause_code_r <= wval_s[5:0]; end
        ADDR_SATP:   satp_r  <= wval_s;
        default:     mie_r   <= mie_r;
      endcase
    end
  end

`ifdef YSYX_23060236_CSR_COUNTERS_EN
  // Counter next values: a write to either half replaces that cycle's increment
  always_comb begin
    if (wr_s && bus.csr_addr == ADDR_MCYCLE) begin
      mcycle_nx_s = {mcycle_r[63:32], wval_s};
    end else if (wr_s && bus.csr_addr == ADDR_MCYCLEH) begin
      mcycle_nx_s = {wval_s, mcycle_r[31:0]};
    end else begin
      mcycle_nx_s = mcycle_r + 64'd1;
    end
    if (wr_s && bus.csr_addr == ADDR_MINSTRET) begin
      minstret_nx_s = {minstret_r[63:32], wval_s};
    end else if (wr_s && bus.csr_addr == ADDR_MINSTRETH) begin
      minstret_nx_s = {wval_s, minstret_r[31:0]};
    end else if (bus.valid && !trap_s) begin
      minstret_nx_s = minstret_r + 64'd1;
    end else begin
      minstret_nx_s = minstret_r;
    end
  end

  // Counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      mcycle_r   <= mcycle_nx_s;
      minstret_r <= minstret_nx_s;
    end
  end
`endif

endmodule
